// File: rtl/reaction_timer_bcd.sv
// ---------------------------------------------------------------------------
// reaction_timer_bcd
//
// Core timing engine of the reaction game. A start pulse begins a round:
// the block waits a pseudo-random 1 ms-granular delay, lights the "go" LED,
// then counts elapsed milliseconds in 4-digit BCD until the player reacts.
// The result is then frozen on the digit outputs. Reacting too early gives
// a false start. The digit outputs feed per-digit 7-segment decoders, and
// 4'hF is the blank code.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//    When defined, leading zero digits are shown as blank (4'hF) in IDLE,
//    ARMED and DONE. bcd0 is never blanked.
//
// Parameters:
//    TICK_CYCLES   clk cycles per 1 ms tick
//    MIN_DELAY_MS  fixed part of the random wait, in ms
//    LFSR_SEED     non-zero reset value of the 10-bit LFSR
//
// Ports:
//    clk          system clock, rising edge
//    reset_n      synchronous active-low reset
//    start        one-cycle pulse, begins a round
//    react        one-cycle pulse, player response
//    led_go       high while measuring (ARMED)
//    busy         high in WAIT or ARMED
//    false_start  high in FALSE
//    bcd3..bcd0   thousands..units digit, or blank code 4'hF
// ---------------------------------------------------------------------------
module reaction_timer_bcd #(
   parameter int         TICK_CYCLES  = 50000,
   parameter int         MIN_DELAY_MS = 1000,
   parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       react,
   output logic       led_go,
   output logic       busy,
   output logic       false_start,
   output logic [3:0] bcd3,
   output logic [3:0] bcd2,
   output logic [3:0] bcd1,
   output logic [3:0] bcd0
);

   localparam int              PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_CYCLES - 1);
   localparam logic [10:0]     DELAY_BASE = 11'(MIN_DELAY_MS);
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [15:0]     RESET_SHOW = 16'hFFF0;
`else
   localparam logic [15:0]     RESET_SHOW = 16'h0000;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ARMED,
      S_DONE,
      S_FALSE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             entering;
   logic             tick;
   logic [PW-1:0]    presc;
   logic [PW-1:0]    presc_next;
   logic [10:0]      delay_cnt;
   logic [10:0]      delay_next;
   logic [9:0]       lfsr;
   logic [3:0][3:0]  count;
   logic [3:0][3:0]  count_inc;
   logic [3:0][3:0]  count_next;
   logic             carry;
   logic [3:0][3:0]  shown;
   logic             led_go_d;
   logic             busy_d;
   logic             false_d;
`ifdef LEADING_ZERO_BLANK_EN
   logic             blank;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // The millisecond tick only exists while a round is in progress.
   assign tick     = ((state == S_WAIT) || (state == S_ARMED)) && (presc == TICK_LAST);
   assign entering = (next_state != state);

   // Next-state logic. In WAIT a react beats an expiring delay and any start,
   // and in the idle-like states a start beats a react.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_DONE, S_FALSE: begin
            if (start) next_state = S_WAIT;
         end
         S_WAIT: begin
            if (react)                            next_state = S_FALSE;
            else if (tick && (delay_cnt <= 11'd1)) next_state = S_ARMED;
         end
         S_ARMED: begin
            if (react) next_state = S_DONE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // BCD increment with ripple carry between digits, holding at 9999.
   always_comb begin
      count_inc = count;
      carry     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (count[i] == 4'd9) begin
               count_inc[i] = 4'd0;
            end else begin
               count_inc[i] = count[i] + 4'd1;
               carry        = 1'b0;
            end
         end
      end
      if (count == 16'h9999) count_inc = count;
   end

   // Datapath next values. The prescaler restarts on every state entry so
   // each state sees full-length ticks. A tick coinciding with react is
   // dropped because the count only advances while staying in ARMED.
   always_comb begin
      if (entering)
         presc_next = '0;
      else if ((state == S_WAIT) || (state == S_ARMED))
         presc_next = tick ? '0 : presc + PW'(1);
      else
         presc_next = '0;

      if ((next_state == S_WAIT) && entering)
         delay_next = DELAY_BASE + {1'b0, lfsr};
      else if ((state == S_WAIT) && tick)
         delay_next = delay_cnt - 11'd1;
      else
         delay_next = delay_cnt;

      if ((next_state == S_ARMED) && entering)
         count_next = '0;
      else if ((state == S_ARMED) && (next_state == S_ARMED) && tick)
         count_next = count_inc;
      else
         count_next = count;
   end

   // Datapath registers. The LFSR runs every cycle so the delay depends on
   // when the player presses start. The zero check is a lock-up guard only.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         presc     <= '0;
         delay_cnt <= '0;
         lfsr      <= LFSR_SEED;
         count     <= '0;
      end else begin
         presc     <= presc_next;
         delay_cnt <= delay_next;
         lfsr      <= (lfsr == 10'd0) ? LFSR_SEED : {lfsr[8:0], lfsr[9] ^ lfsr[6]};
         count     <= count_next;
      end
   end

   // Output decode from the upcoming state and count. The decode is
   // registered below so the outputs change on the same edge as the state.
   always_comb begin
      led_go_d = (next_state == S_ARMED);
      busy_d   = (next_state == S_WAIT) || (next_state == S_ARMED);
      false_d  = (next_state == S_FALSE);
      shown    = count_next;
`ifdef LEADING_ZERO_BLANK_EN
      blank = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         if (blank && (shown[i] == 4'd0)) shown[i] = 4'hF;
         else                             blank    = 1'b0;
      end
`endif
      if ((next_state == S_WAIT) || (next_state == S_FALSE)) shown = 16'hFFFF;
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         led_go                 <= 1'b0;
         busy                   <= 1'b0;
         false_start            <= 1'b0;
         {bcd3, bcd2, bcd1, bcd0} <= RESET_SHOW;
      end else begin
         led_go                 <= led_go_d;
         busy                   <= busy_d;
         false_start            <= false_d;
         {bcd3, bcd2, bcd1, bcd0} <= shown;
      end
   end

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer_bcd
//
// Self-checking bench for reaction_timer_bcd with a 4-cycle tick and a 2 ms
// minimum delay. Round results are predicted from the game rules (reaction
// cycle / tick length, saturating at 9999) and queued. A monitor pops one
// prediction each time busy falls and compares the presented result.
// ---------------------------------------------------------------------------
module tb_reaction_timer_bcd;

   localparam int         TICK  = 4;
   localparam int         MIN_D = 2;
   localparam logic [9:0] SEED  = 10'h2A5;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       start   = 1'b0;
   logic       react   = 1'b0;
   logic       led_go;
   logic       busy;
   logic       false_start;
   logic [3:0] bcd3, bcd2, bcd1, bcd0;

   typedef struct packed {
      logic        fs;
      logic [15:0] digits;
   } exp_t;

   exp_t       sb[$];
   exp_t       got_e;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   logic [9:0] lfsr_m   = SEED;
   logic       prev_busy = 1'b0;

   reaction_timer_bcd #(
      .TICK_CYCLES (TICK),
      .MIN_DELAY_MS(MIN_D),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .react      (react),
      .led_go     (led_go),
      .busy       (busy),
      .false_start(false_start),
      .bcd3       (bcd3),
      .bcd2       (bcd2),
      .bcd1       (bcd1),
      .bcd0       (bcd0)
   );

   always #5 clk = ~clk;

   // Maximal-length sequence for x^10 + x^7 + 1, advancing once per clock.
   function automatic logic [9:0] lfsr_step(input logic [9:0] v);
      return {v[8:0], v[9] ^ v[6]};
   endfunction

   // Cycle counter and pseudo-random source, tracked against the reset pin.
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      lfsr_m <= (!reset_n) ? SEED : lfsr_step(lfsr_m);
   end

   // Decimal digits of a result as the display should present them.
   function automatic logic [15:0] show(input int n);
      logic [3:0] d3, d2, d1, d0;
      d3 = 4'((n / 1000) % 10);
      d2 = 4'((n / 100) % 10);
      d1 = 4'((n / 10) % 10);
      d0 = 4'(n % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (d3 == 4'd0) begin
         d3 = 4'hF;
         if (d2 == 4'd0) begin
            d2 = 4'hF;
            if (d1 == 4'd0) d1 = 4'hF;
         end
      end
`endif
      return {d3, d2, d1, d0};
   endfunction

   // Milliseconds the player is credited with when reacting c cycles after go.
   function automatic int result_ms(input int c);
      int r;
      r = c / TICK;
      if (r > 9999) r = 9999;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic print_summary();
      $display("%0d/%0d checks passed", n_pass, n_checks);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every fall of busy presents a result to compare.
   always @(negedge clk) begin
      if ((prev_busy === 1'b1) && (busy === 1'b0)) begin
         if (sb.size() == 0) begin
            check_output("unexpected_result", {13'd0, false_start, led_go, bcd3, bcd2, bcd1, bcd0}, 32'hFFFF_FFFF);
         end else begin
            got_e = sb.pop_front();
            check_output("result", {false_start, led_go, bcd3, bcd2, bcd1, bcd0},
                         {got_e.fs, 1'b0, got_e.digits});
         end
      end
      prev_busy <= busy;
   end

   // Pulse start (optionally with react); return the expected delay and
   // the cycle stamp at which start was driven.
   task automatic apply_start(input logic with_react, output int d, output int c0);
      d     = MIN_D + int'(lfsr_m);
      c0    = cyc;
      start = 1'b1;
      react = with_react;
      step();
      start = 1'b0;
      react = 1'b0;
      check_output("wait_entry", {busy, led_go, false_start, bcd3, bcd2, bcd1, bcd0},
                   {3'b100, 16'hFFFF});
   endtask

   // Wait for go; its arrival must match d whole milliseconds after start.
   task automatic await_armed(input int d, input int c0);
      int k;
      k = 0;
      while ((led_go !== 1'b1) && (k < TICK * (MIN_D + 1024) + 20)) begin
         step();
         k++;
      end
      if (led_go !== 1'b1) begin
         check_output("armed_timeout", {31'd0, led_go}, 32'd1);
         print_summary();
         $fatal(1, "[TB] go light never came on");
      end
      check_output("wait_len", cyc - c0, TICK * d + 1);
      check_output("armed_entry", {busy, false_start, bcd3, bcd2, bcd1, bcd0}, {2'b10, show(0)});
   endtask

   // React c cycles after the first ARMED cycle and queue the prediction.
   task automatic apply_react(input int c);
      repeat (c) step();
      sb.push_back('{fs: 1'b0, digits: show(result_ms(c))});
      react = 1'b1;
      step();
      react = 1'b0;
   endtask

   task automatic play_round(input int c);
      int d, c0;
      apply_start(1'b0, d, c0);
      await_armed(d, c0);
      apply_react(c);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      print_summary();
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int d, c0;

      // Reset held for three clocks.
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_output("reset_state", {led_go, busy, false_start, bcd3, bcd2, bcd1, bcd0}, {3'b000, show(0)});

      // react alone in IDLE does nothing.
      react = 1'b1;
      step();
      react = 1'b0;
      step();
      check_output("idle_react", {led_go, busy, false_start, bcd3, bcd2, bcd1, bcd0}, {3'b000, show(0)});

      // Normal round, 123 ms, then the result must hold.
      play_round(123 * TICK);
      repeat (1000) step();
      check_output("hold", {led_go, busy, false_start, bcd3, bcd2, bcd1, bcd0}, {3'b000, show(123)});

      // start and react together in DONE: start wins.
      apply_start(1'b1, d, c0);

      // start and react together in WAIT: react wins, false start.
      repeat (4) step();
      sb.push_back('{fs: 1'b1, digits: 16'hFFFF});
      start = 1'b1;
      react = 1'b1;
      step();
      start = 1'b0;
      react = 1'b0;

      // react ignored in FALSE.
      react = 1'b1;
      step();
      react = 1'b0;
      check_output("false_hold", {busy, false_start, bcd3, bcd2, bcd1, bcd0}, {2'b01, 16'hFFFF});

      // Restart from FALSE; react lands on the tick that would make 100.
      play_round(99 * TICK + TICK - 1);

      // Immediate reaction, and fixed values with interesting leading zeros.
      play_round(0);
      play_round(42 * TICK + int'($urandom_range(0, TICK - 1)));
      play_round(1000 * TICK);

      // Random reaction times.
      for (int r = 0; r < 2; r++) play_round(int'($urandom_range(0, 400)));

      // Saturation: well past 9999 ms.
      play_round(10005 * TICK);

      // Reset in the middle of ARMED.
      apply_start(1'b0, d, c0);
      await_armed(d, c0);
      repeat (50) step();
      sb.push_back('{fs: 1'b0, digits: show(0)});
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check_output("reset_mid_armed", {led_go, busy, false_start, bcd3, bcd2, bcd1, bcd0}, {3'b000, show(0)});

      repeat (5) step();
      check_output("scoreboard_drained", sb.size(), 0);
      print_summary();
      $finish;
   end

endmodule
